// File: rtl/red_pitaya_rst_clken_seq_if.sv
// Bundle between the config register bank (master) and the clock-enable /
// reset sequencer (slave). It carries the per-channel enable requests and
// the sequenced clock enable, reset and status outputs.
interface red_pitaya_rst_clken_seq_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] enable_i;
  logic [NCH-1:0] clk_en_o;
  logic [NCH-1:0] reset_n_o;
  logic [NCH-1:0] ready_o;
  logic           busy_o;

  modport master (
    output enable_i,
    input  clk_en_o,
    input  reset_n_o,
    input  ready_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    output clk_en_o,
    output reset_n_o,
    output ready_o,
    output busy_o
  );
endinterface

// File: rtl/red_pitaya_rst_clken_seq.sv
// Per-channel clock-enable / reset sequencer for gated DSP sub-modules.
// Power-up: clock enable first, then reset release ON_DLY+1 edges later.
// Power-down: reset asserted first, then clock enable dropped OFF_DLY+1 edges later.
// Optional macro RST_CLKEN_SEQ_STAGGER_EN: only one channel may be in WAKE at a
// time, lowest index granted first (limits inrush and reset-release bursts).
module red_pitaya_rst_clken_seq #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 4,
  parameter int ON_DLY  = 3,
  parameter int OFF_DLY = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  red_pitaya_rst_clken_seq_if.slave    bus
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_WAKE  = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;
  localparam logic [1:0] ST_SLEEP = 2'd3;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_DLY);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_DLY);

  logic [1:0]       state_reg  [NCH];
  logic [1:0]       state_next [NCH];
  logic [CNT_W-1:0] cnt_reg    [NCH];
  logic [CNT_W-1:0] cnt_next   [NCH];

  // req: channel sitting in OFF/SLEEP that wants to (re)enter WAKE
  logic [NCH-1:0] req;
  logic [NCH-1:0] grant;

  logic [NCH-1:0] clk_en_next;
  logic [NCH-1:0] reset_n_next;
  logic [NCH-1:0] busy_vec;

  logic [NCH-1:0] clk_en_reg;
  logic [NCH-1:0] reset_n_reg;
  logic [NCH-1:0] ready_reg;
  logic           busy_reg;

`ifdef RST_CLKEN_SEQ_STAGGER_EN
  // Channels that will still be in WAKE after this edge; a channel leaving
  // WAKE on this edge frees the slot so the next one starts back-to-back.
  logic [NCH-1:0] stay_wake;

  // Grant the lowest-index requester, only when no channel keeps WAKE
  always_comb begin : grant_comb
    logic found;
    found = 1'b0;
    grant = '0;
    if (stay_wake == '0) begin
      for (int i = 0; i < NCH; i++) begin
        if (req[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  assign grant = req;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign req[gi] = bus.enable_i[gi] &&
                       ((state_reg[gi] == ST_OFF) || (state_reg[gi] == ST_SLEEP));
`ifdef RST_CLKEN_SEQ_STAGGER_EN
      assign stay_wake[gi] = (state_reg[gi] == ST_WAKE) && bus.enable_i[gi] &&
                             (cnt_reg[gi] != '0);
`endif

      // Channel FSM next-state and delay counter
      always_comb begin
        state_next[gi] = state_reg[gi];
        cnt_next[gi]   = cnt_reg[gi];
        case (state_reg[gi])
          ST_OFF: begin
            cnt_next[gi] = '0;
            if (bus.enable_i[gi] && grant[gi]) begin
              state_next[gi] = ST_WAKE;
              cnt_next[gi]   = ON_LOAD;
            end
          end
          ST_WAKE: begin
            if (!bus.enable_i[gi]) begin
              // abort: clock keeps running while the reset stays asserted
              state_next[gi] = ST_SLEEP;
              cnt_next[gi]   = OFF_LOAD;
            end else if (cnt_reg[gi] == '0) begin
              state_next[gi] = ST_ON;
            end else begin
              cnt_next[gi] = cnt_reg[gi] - CNT_W'(1);
            end
          end
          ST_ON: begin
            cnt_next[gi] = '0;
            if (!bus.enable_i[gi]) begin
              state_next[gi] = ST_SLEEP;
              cnt_next[gi]   = OFF_LOAD;
            end
          end
          default: begin // ST_SLEEP
            if (bus.enable_i[gi]) begin
              // without a grant the channel parks here with its counter frozen
              if (grant[gi]) begin
                state_next[gi] = ST_WAKE;
                cnt_next[gi]   = ON_LOAD;
              end
            end else if (cnt_reg[gi] == '0) begin
              state_next[gi] = ST_OFF;
            end else begin
              cnt_next[gi] = cnt_reg[gi] - CNT_W'(1);
            end
          end
        endcase
      end

      // Channel state and counter registers
      always_ff @(posedge clk) begin
        if (!rstn) begin
          state_reg[gi] <= ST_OFF;
          cnt_reg[gi]   <= '0;
        end else begin
          state_reg[gi] <= state_next[gi];
          cnt_reg[gi]   <= cnt_next[gi];
        end
      end

      assign clk_en_next[gi]  = (state_next[gi] != ST_OFF);
      assign reset_n_next[gi] = (state_next[gi] == ST_ON);
      assign busy_vec[gi]     = (state_next[gi] == ST_WAKE) || (state_next[gi] == ST_SLEEP);
    end
  endgenerate

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and have no combinational path from enable_i
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_en_reg  <= '0;
      reset_n_reg <= '0;
      ready_reg   <= '0;
      busy_reg    <= 1'b0;
    end else begin
      clk_en_reg  <= clk_en_next;
      reset_n_reg <= reset_n_next;
      ready_reg   <= reset_n_next & clk_en_next;
      busy_reg    <= |busy_vec;
    end
  end

  assign bus.clk_en_o  = clk_en_reg;
  assign bus.reset_n_o = reset_n_reg;
  assign bus.ready_o   = ready_reg;
  assign bus.busy_o    = busy_reg;

endmodule

// File: tb/tb_red_pitaya_rst_clken_seq.sv
// Testbench for red_pitaya_rst_clken_seq (default parameters). Honours
// RST_CLKEN_SEQ_STAGGER_EN in its reference model and directed checks.
module tb_red_pitaya_rst_clken_seq;

  localparam int NCH     = 4;
  localparam int ON_DLY  = 3;
  localparam int OFF_DLY = 3;
  localparam int LAST_EDGE = 95;

`ifdef RST_CLKEN_SEQ_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  localparam int M_OFF = 0, M_WAKE = 1, M_ON = 2, M_SLEEP = 3;

  typedef struct packed {
    logic [NCH-1:0] clk_en;
    logic [NCH-1:0] reset_n;
    logic [NCH-1:0] ready;
    logic           busy;
  } exp_t;

  logic clk;
  logic rstn;
  red_pitaya_rst_clken_seq_if #(.NCH(NCH)) bus ();

  red_pitaya_rst_clken_seq #(
    .NCH(NCH), .CNT_W(4), .ON_DLY(ON_DLY), .OFF_DLY(OFF_DLY)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  exp_t sb_q[$];

  int m_state [NCH];
  int m_cnt   [NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, want %0h", tag, edge_cnt, got, exp);
    end
  endtask

  // Reference model: advance one edge from the sampled inputs, return the
  // outputs expected right after that edge.
  function automatic exp_t model_step(input logic rst_v, input logic [NCH-1:0] en_v);
    exp_t e;
    bit   wake_kept = 1'b0;
    bit   given = 1'b0;
    if (!rst_v) begin
      for (int c = 0; c < NCH; c++) begin
        m_state[c] = M_OFF;
        m_cnt[c]   = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++)
        if (m_state[c] == M_WAKE && en_v[c] && m_cnt[c] > 0) wake_kept = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (m_state[c] == M_WAKE) begin
          if (!en_v[c]) begin m_state[c] = M_SLEEP; m_cnt[c] = OFF_DLY; end
          else if (m_cnt[c] == 0) m_state[c] = M_ON;
          else m_cnt[c]--;
        end else if (m_state[c] == M_ON) begin
          if (!en_v[c]) begin m_state[c] = M_SLEEP; m_cnt[c] = OFF_DLY; end
        end else if (en_v[c]) begin
          // OFF or SLEEP requesting wake-up
          if (!STAG || (!wake_kept && !given)) begin
            given = 1'b1;
            m_state[c] = M_WAKE;
            m_cnt[c]   = ON_DLY;
          end
        end else if (m_state[c] == M_SLEEP) begin
          if (m_cnt[c] == 0) m_state[c] = M_OFF;
          else m_cnt[c]--;
        end
      end
    end
    e.busy = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      e.clk_en[c]  = (m_state[c] != M_OFF);
      e.reset_n[c] = (m_state[c] == M_ON);
      e.ready[c]   = (m_state[c] == M_ON);
      if (m_state[c] == M_WAKE || m_state[c] == M_SLEEP) e.busy = 1'b1;
    end
    return e;
  endfunction

  // Directed checks taken straight from the expected timeline
  task automatic directed(input int e);
    case (e)
      1:  chk("rst_state", {bus.clk_en_o, bus.reset_n_o, bus.ready_o, 3'b0, bus.busy_o}, 32'h0);
      10: begin chk("ch0_clken_up", bus.clk_en_o[0], 1); chk("ch0_busy", bus.busy_o, 1); end
      13: begin chk("ch0_rst_held", bus.reset_n_o[0], 0); chk("ch0_busy_end", bus.busy_o, 1); end
      14: begin chk("ch0_rst_rel", bus.reset_n_o[0], 1); chk("ch0_ready", bus.ready_o[0], 1);
                chk("ch0_idle", bus.busy_o, 0); end
      20: begin chk("ch0_rst_off", bus.reset_n_o[0], 0); chk("ch0_rdy_off", bus.ready_o[0], 0);
                chk("ch0_clk_hold", bus.clk_en_o[0], 1); end
      23: chk("ch0_clk_late", bus.clk_en_o[0], 1);
      24: chk("ch0_clk_off", bus.clk_en_o[0], 0);
      32: chk("ch1_abort_rst", bus.reset_n_o[1], 0);
      35: begin chk("ch1_abort_rst2", bus.reset_n_o[1], 0); chk("ch1_clk_hold", bus.clk_en_o[1], 1); end
      36: chk("ch1_clk_off", bus.clk_en_o[1], 0);
      42: chk("ch2_sleep_clk", bus.clk_en_o[2], 1);
      43: chk("ch2_rewake_clk", bus.clk_en_o[2], 1);
      46: begin chk("ch2_rst_pend", bus.reset_n_o[2], 0); chk("ch2_clk_keep", bus.clk_en_o[2], 1); end
      47: chk("ch2_rst_rel", bus.reset_n_o[2], 1);
      56: chk("ch3_wake", {bus.clk_en_o[3], bus.reset_n_o[3]}, 2'b10);
      57: chk("mid_rst", {bus.clk_en_o, bus.reset_n_o, bus.ready_o, 3'b0, bus.busy_o}, 32'h0);
`ifdef RST_CLKEN_SEQ_STAGGER_EN
      63: chk("stag_none", bus.reset_n_o, 4'b0000);
      64: chk("stag_1", bus.reset_n_o, 4'b0001);
      67: chk("stag_1b", bus.reset_n_o, 4'b0001);
      68: chk("stag_2", bus.reset_n_o, 4'b0011);
      72: chk("stag_3", bus.reset_n_o, 4'b0111);
      75: chk("stag_3b", bus.reset_n_o, 4'b0111);
      76: chk("stag_4", bus.reset_n_o, 4'b1111);
`else
      63: chk("par_none", bus.reset_n_o, 4'b0000);
      64: chk("par_all", bus.reset_n_o, 4'b1111);
`endif
      89: chk("all_off", bus.clk_en_o, 4'b0000);
      default: ;
    endcase
  endtask

  initial begin
    logic [NCH-1:0] en;
    exp_t exp_v;
    en = '0;
    rstn = 1'b0;
    bus.enable_i = '0;
    for (int m = 0; m < NCH; m++) begin m_state[m] = M_OFF; m_cnt[m] = 0; end
    @(negedge clk);
    for (int e = 1; e <= LAST_EDGE; e++) begin
      case (e)
        10: en[0] = 1'b1;
        20: en[0] = 1'b0;
        30: en[1] = 1'b1;
        32: en[1] = 1'b0;
        36: en[2] = 1'b1;
        42: en[2] = 1'b0;
        43: en[2] = 1'b1;
        48: en[2] = 1'b0;
        55: en[3] = 1'b1;
        57: en[3] = 1'b0;
        60: en = 4'b1111;
        85: en = 4'b0000;
        default: ;
      endcase
      rstn = !((e <= 2) || (e == 57));
      bus.enable_i = en;
      sb_q.push_back(model_step(rstn, en));
      @(posedge clk);
      #1;
      edge_cnt = e;
      exp_v = sb_q.pop_front();
      $display("edge %0d rstn=%b en=%b clk_en=%b reset_n=%b ready=%b busy=%b",
               e, rstn, en, bus.clk_en_o, bus.reset_n_o, bus.ready_o, bus.busy_o);
      chk("clk_en", bus.clk_en_o, exp_v.clk_en);
      chk("reset_n", bus.reset_n_o, exp_v.reset_n);
      chk("ready", bus.ready_o, exp_v.ready);
      chk("busy", bus.busy_o, exp_v.busy);
      chk("inv_rst_clk", bus.reset_n_o & ~bus.clk_en_o, 0);
      directed(e);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
